// File: rtl/prog_mem_responder_if.sv
// Fetch-path bundle between the fetch unit (master) and the program-memory
// responder (slave): request address channel plus response word channel.
interface prog_mem_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 14
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] prog_adr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] prog_dat;
  logic [ADDR_W-1:0] rsp_adr;
  logic              rsp_err;

  modport master (
    output req_valid, prog_adr, rsp_ready,
    input  req_ready, rsp_valid, prog_dat, rsp_adr, rsp_err
  );

  modport slave (
    input  req_valid, prog_adr, rsp_ready,
    output req_ready, rsp_valid, prog_dat, rsp_adr, rsp_err
  );
endinterface

// File: rtl/prog_mem_responder.sv
// Program-memory responder: DEPTH-word array loaded through a write port,
// 2-stage read pipeline feeding a credit-guarded response FIFO.
// Optional feature macro: PROG_MEM_STALL_STATS_EN enables the saturating
// backpressure stall counter on stall_cnt_o (tied to zero otherwise).
module prog_mem_responder #(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 14,
  parameter int                DEPTH      = 64,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
  input  logic                     clk,
  input  logic                     pon_rst_n_i,
  prog_mem_if.slave                bus_if,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_adr_i,
  input  logic [DATA_W-1:0]        wr_dat_i,
  output logic [ADDR_W-1:0]        acc_cnt_o,
  output logic [15:0]              stall_cnt_o
);
  localparam int LW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              s1_vld_q, s2_vld_q;
  logic [ADDR_W-1:0] s1_adr_q, s2_adr_q;
  logic [DATA_W-1:0] s1_dat_q, s2_dat_q;
  logic              s1_err_q, s2_err_q;

  logic [DATA_W-1:0] fifo_dat_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_adr_q [FIFO_DEPTH];
  logic              fifo_err_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] acc_q;

  logic              in_range, accept, push, pop;
  logic [DATA_W-1:0] rd_word;
  logic [UW-1:0]     used;

  // Out-of-range addresses never alias into the array; compare full width.
  assign in_range = bus_if.prog_adr < ADDR_W'(DEPTH);
  assign rd_word  = in_range ? mem_q[bus_if.prog_adr[LW-1:0]] : NOP_WORD;

  // Credits count every word already owed to the FIFO, so a full pipeline
  // can never overflow it; a same-cycle pop only frees a credit next cycle.
  assign used = UW'(cnt_q) + UW'(s1_vld_q) + UW'(s2_vld_q);
  assign bus_if.req_ready = used < UW'(FIFO_DEPTH);

  assign accept = bus_if.req_valid & bus_if.req_ready;
  assign push   = s2_vld_q;
  assign pop    = (cnt_q != '0) & bus_if.rsp_ready;

  assign bus_if.rsp_valid = cnt_q != '0;
  assign bus_if.prog_dat  = fifo_dat_q[rd_ptr_q];
  assign bus_if.rsp_adr   = fifo_adr_q[rd_ptr_q];
  assign bus_if.rsp_err   = fifo_err_q[rd_ptr_q];
  assign acc_cnt_o        = acc_q;

  // Program array: cleared by reset, written through the load port. A read
  // in the same edge as a write to that address sees the old word.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_adr_i] <= wr_dat_i;
    end
  end

  // Two-stage read pipeline: S1 captures the array word at accept, S2 delays
  // one more cycle and pushes into the FIFO.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      s1_vld_q <= 1'b0; s1_adr_q <= '0; s1_dat_q <= '0; s1_err_q <= 1'b0;
      s2_vld_q <= 1'b0; s2_adr_q <= '0; s2_dat_q <= '0; s2_err_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_adr_q <= bus_if.prog_adr;
        s1_dat_q <= rd_word;
        s1_err_q <= ~in_range;
        acc_q    <= acc_q + 1'b1;
      end
      s2_vld_q <= s1_vld_q;
      s2_adr_q <= s1_adr_q;
      s2_dat_q <= s1_dat_q;
      s2_err_q <= s1_err_q;
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Response FIFO storage and pointers; storage is cleared so the head
  // outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat_q[i] <= '0;
        fifo_adr_q[i] <= '0;
        fifo_err_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_dat_q[wr_ptr_q] <= s2_dat_q;
        fifo_adr_q[wr_ptr_q] <= s2_adr_q;
        fifo_err_q[wr_ptr_q] <= s2_err_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

`ifdef PROG_MEM_STALL_STATS_EN
  logic [15:0] stall_q;
  assign stall_cnt_o = stall_q;

  // Count cycles the fetch unit is held off by credits, saturating.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      stall_q <= '0;
    end else if (bus_if.req_valid && !bus_if.req_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign stall_cnt_o = 16'h0;
`endif
endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed self-checking bench for prog_mem_responder.
module tb_prog_mem_responder;
  logic        clk;
  logic        pon_rst_n_i;
  logic        wr_en_i;
  logic [5:0]  wr_adr_i;
  logic [13:0] wr_dat_i;
  logic [12:0] acc_cnt_o;
  logic [15:0] stall_cnt_o;

  int total;
  int bad;
  int exp_acc;
  int idx;
  logic acc_now;

  prog_mem_if #(.ADDR_W(13), .DATA_W(14)) bus ();

  prog_mem_responder dut (
    .clk         (clk),
    .pon_rst_n_i (pon_rst_n_i),
    .bus_if      (bus),
    .wr_en_i     (wr_en_i),
    .wr_adr_i    (wr_adr_i),
    .wr_dat_i    (wr_dat_i),
    .acc_cnt_o   (acc_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    pon_rst_n_i = 1'b0;
    step();
    step();
    pon_rst_n_i = 1'b1;
    exp_acc = 0;
  endtask

  task automatic write_word(input logic [5:0] a, input logic [13:0] d);
    wr_en_i = 1'b1; wr_adr_i = a; wr_dat_i = d;
    step();
    wr_en_i = 1'b0;
  endtask

  // Single request with rsp_ready high: response visible after edge N+2.
  task automatic single_req(input string tag, input logic [12:0] a,
                            input logic [13:0] exp_dat, input logic exp_err);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.prog_adr = a;
    step();
    bus.req_valid = 1'b0;
    exp_acc++;
    step();
    chk({tag, "_notyet"}, 32'(bus.rsp_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_dat"},   32'(bus.prog_dat),  32'(exp_dat));
    chk({tag, "_adr"},   32'(bus.rsp_adr),   32'(a));
    chk({tag, "_err"},   32'(bus.rsp_err),   32'(exp_err));
    step();
    chk({tag, "_popped"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; exp_acc = 0;
    pon_rst_n_i = 1'b0;
    wr_en_i = 1'b0; wr_adr_i = '0; wr_dat_i = '0;
    bus.req_valid = 1'b0; bus.prog_adr = '0; bus.rsp_ready = 1'b0;
    do_reset();

    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_acc",   32'(acc_cnt_o),     32'd0);
    chk("rst_stall", 32'(stall_cnt_o),   32'd0);

    // Basic read with 2-cycle latency.
    write_word(6'd5, 14'h1A3C);
    single_req("rd5", 13'd5, 14'h1A3C, 1'b0);

    // Range boundaries: last valid word, first invalid, no aliasing of 0x45 to 5.
    single_req("rd3f", 13'h003F, 14'h0000, 1'b0);
    single_req("rd40", 13'h0040, 14'h0000, 1'b1);
    single_req("rd45", 13'h0045, 14'h0000, 1'b1);

    // Same-edge write and read of address 7 returns the old word.
    write_word(6'd7, 14'h0011);
    wr_en_i = 1'b1; wr_adr_i = 6'd7; wr_dat_i = 14'h3FFF;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.prog_adr = 13'd7;
    step();
    wr_en_i = 1'b0; bus.req_valid = 1'b0; exp_acc++;
    step();
    step();
    chk("wrrd_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wrrd_old",   32'(bus.prog_dat),  32'h0011);
    step();
    single_req("rd7new", 13'd7, 14'h3FFF, 1'b0);
    chk("acc_cnt", 32'(acc_cnt_o), 32'(exp_acc));

    // Credit limit: stream 0..9 with consumer stalled; only 4 fit.
    for (int i = 0; i < 10; i++) write_word(6'(i), 14'(14'h100 + i));
    bus.rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 1'b1; bus.prog_adr = 13'(idx);
      acc_now = bus.req_ready;
      step();
      if (acc_now) idx++;
    end
    bus.req_valid = 1'b0;
    chk("credit_accepts", 32'(idx), 32'd4);
    chk("credit_ready",   32'(bus.req_ready), 32'd0);
    // Head holds while stalled.
    step();
    chk("hold_dat", 32'(bus.prog_dat), 32'h100);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("drain%0d_dat", k),   32'(bus.prog_dat),  32'(14'h100 + k));
      chk($sformatf("drain%0d_adr", k),   32'(bus.rsp_adr),   32'(k));
      step();
    end
    chk("drain_empty", 32'(bus.rsp_valid), 32'd0);
    chk("drain_ready", 32'(bus.req_ready), 32'd1);

    // Reset mid-burst: outputs clear within the same cycle.
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.prog_adr = 13'd5;
    step(); step(); step();
    #3;
    pon_rst_n_i = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_acc",   32'(acc_cnt_o),     32'd0);
    chk("midrst_dat",   32'(bus.prog_dat),  32'd0);
    chk("midrst_adr",   32'(bus.rsp_adr),   32'd0);
    chk("midrst_err",   32'(bus.rsp_err),   32'd0);
    chk("midrst_stall", 32'(stall_cnt_o),   32'd0);
    bus.req_valid = 1'b0;
    do_reset();
    // Array was cleared by reset.
    single_req("rd5_after_rst", 13'd5, 14'h0000, 1'b0);

    // Accept counter wraps 8191 -> 0.
    do_reset();
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.prog_adr = 13'd1;
    for (int c = 0; c < 8191; c++) step();
    chk("acc_max", 32'(acc_cnt_o), 32'h1FFF);
    step();
    chk("acc_wrap", 32'(acc_cnt_o), 32'd0);
    bus.req_valid = 1'b0;
    step(); step(); step(); step();

    // Stall statistics: 4 fill cycles then 100 stalled cycles.
    do_reset();
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.prog_adr = 13'd0;
    for (int c = 0; c < 104; c++) step();
    bus.req_valid = 1'b0;
`ifdef PROG_MEM_STALL_STATS_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'd100);
`else
    chk("stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    chk("stall_acc", 32'(acc_cnt_o), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
